// File: rtl/riscv_pkg.sv
// Shared RV32I memory-stage definitions: funct3 codes,
// fault causes and load/store unit state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ALIGN   = 2'b01,
    CAUSE_BUS     = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } faultCause_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsuState_e;

  function automatic logic legalF3(
    input logic       isStore,
    input logic [2:0] f3
  );
    logic ok;
    if (isStore)
      ok = f3 inside {F3_SB, F3_SH, F3_SW};
    else
      ok = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication, load
// extraction/extension and natural-alignment check.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [7:0]  lByte;
  logic [15:0] lHalf;

  assign lByte = data[{addrLo, 3'b000} +: 8];
  assign lHalf = addrLo[1] ? data[31:16] : data[15:0];

  always_comb begin
    be       = 4'b1111;
    wdata    = data;
    ldata    = data;
    misalign = 1'b0;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        be    = 4'b0001 << addrLo;
        wdata = {4{data[7:0]}};
        ldata = funct3[2] ? {24'b0, lByte}
                          : {{24{lByte[7]}}, lByte};
      end
      funct3[1:0] == 2'b01: begin
        be       = 4'b0011 << {addrLo[1], 1'b0};
        wdata    = {2{data[15:0]}};
        misalign = addrLo[0];
        ldata    = funct3[2] ? {16'b0, lHalf}
                             : {{16{lHalf[15]}}, lHalf};
      end
      funct3[1:0] == 2'b10: begin
        misalign = |addrLo;
      end
      default: begin
        // width 11 is rejected as an illegal funct3 upstream
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: req/ack data bus, alignment,
// fault reporting and pipeline stall generation.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  output logic [1:0]  FaultCause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  lsuState_e   state;
  lsuState_e   stateNext;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic [3:0]  beQ;
  logic        weQ;
  logic [2:0]  funct3Q;
  logic [15:0] cnt;

  logic        access;
  logic        bad;
  logic        timeUp;
  logic        inReq;
  logic [3:0]  inBe;
  logic [31:0] inWdata;
  logic        inMisalign;
  logic [31:0] rdLdata;

  logic [31:0] inLdataUnused;
  logic [3:0]  rdBeUnused;
  logic [31:0] rdWdataUnused;
  logic        rdMisUnused;
  logic        unusedAlign;

  lsu_align uAlignIn (
    .funct3   (Funct3M),
    .addrLo   (AddrM[1:0]),
    .data     (WriteDataM),
    .be       (inBe),
    .wdata    (inWdata),
    .ldata    (inLdataUnused),
    .misalign (inMisalign)
  );

  lsu_align uAlignRd (
    .funct3   (funct3Q),
    .addrLo   (addrQ[1:0]),
    .data     (bus_rdata),
    .be       (rdBeUnused),
    .wdata    (rdWdataUnused),
    .ldata    (rdLdata),
    .misalign (rdMisUnused)
  );

  assign unusedAlign = ^{inLdataUnused, rdBeUnused,
                         rdWdataUnused, rdMisUnused};

  assign access = MemReadM | MemWriteM;
  assign bad    = inMisalign | ~legalF3(MemWriteM, Funct3M);
  assign timeUp = cnt == 16'(TIMEOUT - 1);
  assign inReq  = state == REQ;

  assign bus_req   = inReq;
  assign bus_we    = inReq & weQ;
  assign bus_addr  = inReq ? {addrQ[31:2], 2'b00} : '0;
  assign bus_wdata = inReq ? wdataQ : '0;
  assign bus_be    = inReq ? beQ : '0;

  always_comb begin
    stateNext = state;
    StallM    = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          if (bad) begin
            stateNext = DONE;
          end else begin
            StallM    = 1'b1;
            stateNext = REQ;
          end
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (bus_err | bus_ack | timeUp)
          stateNext = DONE;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addrQ      <= '0;
      wdataQ     <= '0;
      beQ        <= '0;
      weQ        <= 1'b0;
      funct3Q    <= '0;
      cnt        <= '0;
      ReadDataM  <= '0;
      FaultM     <= 1'b0;
      FaultCause <= CAUSE_NONE;
    end else begin
      state      <= stateNext;
      FaultM     <= 1'b0;
      FaultCause <= CAUSE_NONE;
      if (state == IDLE && access) begin
        if (bad) begin
          FaultM     <= 1'b1;
          FaultCause <= CAUSE_ALIGN;
          ReadDataM  <= '0;
        end else begin
          addrQ   <= AddrM;
          weQ     <= MemWriteM;
          funct3Q <= Funct3M;
          beQ     <= MemWriteM ? inBe : 4'b1111;
          wdataQ  <= MemWriteM ? inWdata : '0;
          cnt     <= '0;
        end
      end
      if (inReq) begin
        cnt <= cnt + 16'd1;
        if (bus_err) begin
          FaultM     <= 1'b1;
          FaultCause <= CAUSE_BUS;
          ReadDataM  <= '0;
        end else if (bus_ack) begin
          ReadDataM <= rdLdata;
        end else if (timeUp) begin
          FaultM     <= 1'b1;
          FaultCause <= CAUSE_TIMEOUT;
          ReadDataM  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes model
// results, a negedge monitor pops them at access completion.
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] AddrM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, FaultM;
  logic [1:0]  FaultCause;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack, bus_err;

  typedef struct {
    logic        busUsed;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          reqs;
    int          stalls;
    logic        chkRd;
    logic [31:0] rd;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t        expQ[$];
  int          nChecks = 0;
  int          nFails = 0;
  logic        monEn = 1'b0;
  logic        prevStall = 1'b0;
  logic        lastKnown = 1'b0;
  logic [31:0] lastRd = '0;
  int          stallCnt = 0;
  logic        monDone;
  exp_t        monE;
  logic [2:0]  ldF3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .FaultM     (FaultM),
    .FaultCause (FaultCause),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: sizes, lanes and extension by arithmetic
  function automatic exp_t model(
    input logic rd, input logic wr, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rdat, input int dly, input int mode);
    exp_t   e;
    int     off, n;
    logic   legal;
    longint v;
    e = '{default: 0};
    off = int'(a % 32'd4);
    n = 1 << int'(f3 % 3'd4);
    legal = wr ? (f3 <= 3'd2) : (f3 inside {0, 1, 2, 4, 5});
    legal = legal && (off % n == 0);
    if (!legal) begin
      e.fault = 1'b1;
      e.cause = 2'd1;
      return e;
    end
    e.busUsed = 1'b1;
    e.we = wr;
    e.addr = a - 32'(off);
    if (wr) begin
      e.be = 4'(((1 << n) - 1) << off);
      if (n == 1)      e.wdata = (wd & 32'hFF) * 32'h01010101;
      else if (n == 2) e.wdata = (wd & 32'hFFFF) * 32'h00010001;
      else             e.wdata = wd;
    end else begin
      e.be = 4'hF;
      e.wdata = '0;
    end
    e.reqs = (mode == 2) ? TO : dly;
    e.stalls = e.reqs + 1;
    e.chkRd = 1'b1;
    if (mode == 1) begin
      e.fault = 1'b1;
      e.cause = 2'd2;
    end else if (mode == 2) begin
      e.fault = 1'b1;
      e.cause = 2'd3;
    end else begin
      v = longint'(rdat >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
      if (f3 < 3'd4 && n < 4 && v >= (64'd1 << (8 * n - 1)))
        v -= (64'd1 << (8 * n));
      e.rd = 32'(v);
    end
    return e;
  endfunction

  // mode: 0 ack, 1 bus_err, 2 no response (timeout)
  task automatic doAccess(
    input logic rd, input logic wr, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rdat, input int dly, input int mode);
    exp_t e;
    int   reqCyc = 0;
    int   n = 0;
    e = model(rd, wr, f3, a, wd, rdat, dly, mode);
    expQ.push_back(e);
    MemReadM = rd;
    MemWriteM = wr;
    Funct3M = f3;
    AddrM = a;
    WriteDataM = wd;
    do begin
      @(posedge clk); #1;
      n++;
      bus_ack = 1'b0;
      bus_err = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        reqCyc++;
        if (mode != 2 && reqCyc == dly) begin
          if (mode == 1) bus_err = 1'b1;
          else           bus_ack = 1'b1;
          bus_rdata = rdat;
        end
      end
    end while (bus_req && n < 100);
    check("reqCycles", reqCyc, e.reqs);
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_ReadDataM"}, ReadDataM, 0);
    check({tag, "_StallM"}, StallM, 0);
    check({tag, "_FaultM"}, FaultM, 0);
    check({tag, "_FaultCause"}, FaultCause, 0);
    check({tag, "_bus_req"}, bus_req, 0);
    check({tag, "_bus_we"}, bus_we, 0);
    check({tag, "_bus_addr"}, bus_addr, 0);
    check({tag, "_bus_wdata"}, bus_wdata, 0);
    check({tag, "_bus_be"}, bus_be, 0);
  endtask

  always @(negedge clk) begin
    if (!monEn) begin
      prevStall = 1'b0;
      stallCnt = 0;
      lastKnown = 1'b0;
    end else begin
      if (bus_req) begin
        if (expQ.size() == 0) begin
          check("busReqUnexpected", bus_req, 0);
        end else begin
          check("busReqAllowed", bus_req, expQ[0].busUsed);
          check("bus_we", bus_we, expQ[0].we);
          check("bus_addr", bus_addr, expQ[0].addr);
          check("bus_be", bus_be, expQ[0].be);
          check("bus_wdata", bus_wdata, expQ[0].wdata);
        end
      end
      monDone = FaultM || (prevStall && !StallM);
      if (monDone) begin
        if (expQ.size() == 0) begin
          check("doneUnexpected", monDone, 0);
        end else begin
          monE = expQ.pop_front();
          check("FaultM", FaultM, monE.fault);
          check("FaultCause", FaultCause, monE.cause);
          check("stallCycles", stallCnt, monE.stalls);
          if (monE.chkRd) check("ReadDataM", ReadDataM, monE.rd);
          lastKnown = monE.chkRd;
          lastRd = monE.rd;
        end
      end else if (lastKnown) begin
        check("ReadDataHold", ReadDataM, lastRd);
      end
      stallCnt = monDone ? 0 : stallCnt + int'(StallM);
      prevStall = StallM;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int         kind, mode, r;
    reset = 1'b0;
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    Funct3M = '0;
    AddrM = '0;
    WriteDataM = '0;
    bus_rdata = '0;
    bus_ack = 1'b0;
    bus_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b1;
    monEn = 1'b1;

    doAccess(1'b0, 1'b1, 3'b000, 32'h103, 32'hAB, '0, 1, 0);
    doAccess(1'b1, 1'b0, 3'b000, 32'h102, '0, 32'h00F10000, 1, 0);
    doAccess(1'b1, 1'b0, 3'b100, 32'h102, '0, 32'h00F10000, 1, 0);
    doAccess(1'b1, 1'b0, 3'b101, 32'h102, '0, 32'h00F10000, 2, 0);
    doAccess(1'b1, 1'b0, 3'b001, 32'h102, '0, 32'h80010000, 1, 0);
    doAccess(1'b1, 1'b0, 3'b010, 32'h106, '0, 32'h12345678, 1, 0);
    doAccess(1'b1, 1'b0, 3'b010, 32'h108, '0, 32'h12345678, 5, 0);
    doAccess(1'b1, 1'b0, 3'b010, 32'h10C, '0, '0, 1, 2);
    doAccess(1'b1, 1'b0, 3'b010, 32'h10C, '0, '0, 3, 1);
    doAccess(1'b1, 1'b0, 3'b011, 32'h110, '0, '0, 1, 0);
    doAccess(1'b0, 1'b1, 3'b100, 32'h110, 32'h55, '0, 1, 0);
    doAccess(1'b1, 1'b1, 3'b001, 32'h112, 32'hBEEF, '0, 1, 0);
    doAccess(1'b1, 1'b0, 3'b010, 32'h114, '0, 32'hCAFEF00D, TO, 0);

    monEn = 1'b0;
    MemReadM = 1'b1;
    Funct3M = 3'b010;
    AddrM = 32'h200;
    @(posedge clk); #1;
    check("rst_midReq", bus_req, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    MemReadM = 1'b0;
    @(posedge clk); #1;
    checkAllZero("midReset");
    reset = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    checkAllZero("lateAck");
    monEn = 1'b1;
    doAccess(1'b0, 1'b1, 3'b010, 32'h204, 32'h01234567, '0, 2, 0);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 5);
      rd = (kind < 3) || (kind == 5);
      wr = (kind >= 3);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr) f3 = 3'($urandom_range(0, 2));
      else f3 = ldF3[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 2) != 0)
        a = a & ~32'((1 << int'(f3 % 3'd4)) - 1);
      r = $urandom_range(0, 19);
      mode = (r < 16) ? 0 : (r < 19) ? 1 : 2;
      doAccess(rd, wr, f3, a, $urandom, $urandom,
               $urandom_range(1, TO), mode);
    end

    repeat (2) @(posedge clk);
    #1;
    check("queueDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
